// File: rtl/game_ctrl_pkg.sv
// Shared constants for the game controller: state encoding, default parameters, row-width helper.
package game_ctrl_pkg;

  localparam int unsigned DEF_ROWS            = 20;
  localparam int unsigned DEF_LOCK_CYCLES     = 8;
  localparam int unsigned DEF_DROP_BASE       = 1000;
  localparam int unsigned DEF_DROP_STEP       = 50;
  localparam int unsigned DEF_DROP_MIN        = 100;
  localparam int unsigned DEF_LINES_PER_LEVEL = 10;
  localparam int unsigned DEF_MAX_LEVEL       = 15;
  localparam int unsigned DEF_LINES_W         = 16;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned LOCK_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_NEWBOARD = 3'd0,
    ST_GEN      = 3'd1,
    ST_MOVE     = 3'd2,
    ST_LAND     = 3'd3,
    ST_CLEAR    = 3'd4,
    ST_GAMEOVER = 3'd5,
    ST_PAUSE    = 3'd6
  } state_t;

  // Row index width; never below one bit so tiny boards still get a usable index.
  function automatic int unsigned row_w(input int unsigned rows);
    return (rows > 2) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_gravity_timer.sv
// Gravity timer: level-scaled drop period, latched at piece entry, with clear/run control.
module gravity_timer
  import game_ctrl_pkg::*;
#(
  parameter int unsigned DROP_BASE = DEF_DROP_BASE,
  parameter int unsigned DROP_STEP = DEF_DROP_STEP,
  parameter int unsigned DROP_MIN  = DEF_DROP_MIN
) (
  input  logic               clka,
  input  logic               restart,
  input  logic               i_clear,
  input  logic               i_run,
  input  logic [LEVEL_W-1:0] i_level,
  output logic               o_drop_tick
);

  localparam int unsigned FLOOR = (DROP_MIN == 0) ? 1 : DROP_MIN;
  localparam int unsigned PMAX  = (DROP_BASE > FLOOR) ? DROP_BASE : FLOOR;
  localparam int unsigned CNT_W = $clog2(PMAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period;
  logic             r_tick;
  int unsigned      w_reduce;

  // Subtraction guarded so a high level clips to the floor instead of wrapping.
  always_comb begin
    w_reduce = 32'(i_level) * DROP_STEP;
    if ((DROP_BASE > w_reduce) && ((DROP_BASE - w_reduce) > FLOOR)) begin
      w_period = CNT_W'(DROP_BASE - w_reduce);
    end else begin
      w_period = CNT_W'(FLOOR);
    end
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      r_cnt    <= '0;
      r_period <= CNT_W'(PMAX);
      r_tick   <= 1'b0;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_period <= w_period;
      r_tick   <= 1'b0;
    end else if (i_run) begin
      if (r_cnt >= r_period - CNT_W'(1)) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_drop_tick = r_tick;

endmodule

// File: rtl/game_ctrl_fsm.sv
// Tetris game controller: spawn, gravity, lock delay, row clearing, levels and game over.
// Optional pause (pause_btn input, PAUSE state) enabled by defining GAME_CTRL_PAUSE_EN.
module game_ctrl_fsm
  import game_ctrl_pkg::*;
#(
  parameter int unsigned ROWS            = DEF_ROWS,
  parameter int unsigned LOCK_CYCLES     = DEF_LOCK_CYCLES,
  parameter int unsigned DROP_BASE       = DEF_DROP_BASE,
  parameter int unsigned DROP_STEP       = DEF_DROP_STEP,
  parameter int unsigned DROP_MIN        = DEF_DROP_MIN,
  parameter int unsigned LINES_PER_LEVEL = DEF_LINES_PER_LEVEL,
  parameter int unsigned MAX_LEVEL       = DEF_MAX_LEVEL,
  parameter int unsigned LINES_W         = DEF_LINES_W,
  localparam int unsigned ROW_W          = row_w(ROWS)
) (
  input  logic               clka,
  input  logic               restart,
  input  logic               gen_ack,
  input  logic               spawn_blocked,
  input  logic               placed,
  input  logic               row_full,
  input  logic               clear_ack,
`ifdef GAME_CTRL_PAUSE_EN
  input  logic               pause_btn,
`endif
  output logic [STATE_W-1:0] state,
  output logic               gen_req,
  output logic               drop_tick,
  output logic               land,
  output logic [ROW_W-1:0]   row_sel,
  output logic               clear_req,
  output logic [LINES_W-1:0] lines_total,
  output logic [LEVEL_W-1:0] level
);

  localparam int unsigned LIL_W = $clog2(LINES_PER_LEVEL + 1);

  state_t             r_state;
  logic               r_gen_req;
  logic               r_land;
  logic               r_clear_req;
  logic [ROW_W-1:0]   r_row_sel;
  logic [LINES_W-1:0] r_lines;
  logic [LEVEL_W-1:0] r_level;
  logic [LIL_W-1:0]   r_lil;
  logic [LOCK_W-1:0]  r_lock;
  logic               w_grav_clear;
  logic               w_grav_run;
  logic               w_pause_rise;

`ifdef GAME_CTRL_PAUSE_EN
  logic r_pause_d;

  always_ff @(posedge clka) begin
    if (restart) r_pause_d <= 1'b0;
    else         r_pause_d <= pause_btn;
  end

  assign w_pause_rise = pause_btn & ~r_pause_d;
`else
  assign w_pause_rise = 1'b0;
`endif

  assign w_grav_clear = (r_state == ST_GEN) && gen_ack && !spawn_blocked;
  assign w_grav_run   = (r_state == ST_MOVE) && !w_pause_rise;

  gravity_timer #(
    .DROP_BASE (DROP_BASE),
    .DROP_STEP (DROP_STEP),
    .DROP_MIN  (DROP_MIN)
  ) u_gravity (
    .clka        (clka),
    .restart     (restart),
    .i_clear     (w_grav_clear),
    .i_run       (w_grav_run),
    .i_level     (r_level),
    .o_drop_tick (drop_tick)
  );

  always_ff @(posedge clka) begin
    if (restart) begin
      r_state     <= ST_NEWBOARD;
      r_gen_req   <= 1'b0;
      r_land      <= 1'b0;
      r_clear_req <= 1'b0;
      r_row_sel   <= ROW_W'(ROWS - 1);
      r_lines     <= '0;
      r_level     <= '0;
      r_lil       <= '0;
      r_lock      <= '0;
    end else begin
      r_land <= 1'b0;
      case (r_state)
        ST_NEWBOARD: begin
          r_state   <= ST_GEN;
          r_gen_req <= 1'b1;
        end
        ST_GEN: begin
          if (gen_ack) begin
            r_gen_req <= 1'b0;
            r_lock    <= '0;
            r_state   <= spawn_blocked ? ST_GAMEOVER : ST_MOVE;
          end
        end
        ST_MOVE: begin
          // Lock fires on the LOCK_CYCLES-th consecutive placed cycle.
          if (w_pause_rise) begin
`ifdef GAME_CTRL_PAUSE_EN
            r_state <= ST_PAUSE;
`endif
          end else if (placed) begin
            if (r_lock == LOCK_W'(LOCK_CYCLES - 1)) begin
              r_state <= ST_LAND;
              r_land  <= 1'b1;
              r_lock  <= '0;
            end else begin
              r_lock <= r_lock + LOCK_W'(1);
            end
          end else begin
            r_lock <= '0;
          end
        end
        ST_LAND: begin
          r_state   <= ST_CLEAR;
          r_row_sel <= ROW_W'(ROWS - 1);
        end
        ST_CLEAR: begin
          // After a delete the same row is rescanned since upper rows shifted into it.
          if (r_clear_req) begin
            if (clear_ack) begin
              r_clear_req <= 1'b0;
              if (r_lines != '1) r_lines <= r_lines + LINES_W'(1);
              if (r_lil == LIL_W'(LINES_PER_LEVEL - 1)) begin
                r_lil <= '0;
                if (r_level != LEVEL_W'(MAX_LEVEL)) r_level <= r_level + LEVEL_W'(1);
              end else begin
                r_lil <= r_lil + LIL_W'(1);
              end
            end
          end else if (row_full) begin
            r_clear_req <= 1'b1;
          end else if (r_row_sel != '0) begin
            r_row_sel <= r_row_sel - ROW_W'(1);
          end else begin
            r_state   <= ST_GEN;
            r_gen_req <= 1'b1;
          end
        end
        ST_GAMEOVER: begin
          r_state <= ST_GAMEOVER;
        end
`ifdef GAME_CTRL_PAUSE_EN
        ST_PAUSE: begin
          if (w_pause_rise) r_state <= ST_MOVE;
        end
`endif
        default: begin
          r_state <= ST_NEWBOARD;
        end
      endcase
    end
  end

  assign state       = r_state;
  assign gen_req     = r_gen_req;
  assign land        = r_land;
  assign row_sel     = r_row_sel;
  assign clear_req   = r_clear_req;
  assign lines_total = r_lines;
  assign level       = r_level;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm on a 4-row board with short gravity and lock timing.
module tb_game_ctrl_fsm;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned ROW_W = 2;

  logic             clka = 1'b0;
  logic             restart;
  logic             gen_ack;
  logic             spawn_blocked;
  logic             placed;
  logic             row_full;
  logic             clear_ack;
  logic             pause_btn;
  logic [2:0]       state;
  logic             gen_req;
  logic             drop_tick;
  logic             land;
  logic [ROW_W-1:0] row_sel;
  logic             clear_req;
  logic [15:0]      lines_total;
  logic [3:0]       level;
  logic [ROWS-1:0]  brd;

  int errors = 0;
  int checks = 0;

  always #5 clka = ~clka;

  assign row_full = brd[row_sel];

  game_ctrl_fsm #(
    .ROWS            (4),
    .LOCK_CYCLES     (4),
    .DROP_BASE       (10),
    .DROP_STEP       (4),
    .DROP_MIN        (3),
    .LINES_PER_LEVEL (2),
    .MAX_LEVEL       (15),
    .LINES_W         (16)
  ) dut (
    .clka          (clka),
    .restart       (restart),
    .gen_ack       (gen_ack),
    .spawn_blocked (spawn_blocked),
    .placed        (placed),
    .row_full      (row_full),
    .clear_ack     (clear_ack),
`ifdef GAME_CTRL_PAUSE_EN
    .pause_btn     (pause_btn),
`endif
    .state         (state),
    .gen_req       (gen_req),
    .drop_tick     (drop_tick),
    .land          (land),
    .row_sel       (row_sel),
    .clear_req     (clear_req),
    .lines_total   (lines_total),
    .level         (level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clka);
  endtask

  task automatic spawn(input logic blocked);
    gen_ack       = 1'b1;
    spawn_blocked = blocked;
    cyc(1);
    gen_ack       = 1'b0;
    spawn_blocked = 1'b0;
  endtask

  // Expect a tick on every period-th cycle after MOVE entry.
  task automatic gravity_window(input int n, input int period, input string tag);
    for (int k = 1; k <= n; k++) begin
      cyc(1);
      check(tag, 32'(drop_tick), ((k % period) == 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic lock_piece();
    placed = 1'b1;
    cyc(4);
    placed = 1'b0;
    check("lock_land_state", 32'(state), 3);
  endtask

  // Board model: acks each clear_req two cycles later and shifts rows above down.
  task automatic run_clear(input int budget, input int exp_row, output int ncl);
    int wait_cnt;
    wait_cnt = 0;
    ncl      = 0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (clear_ack) begin
        clear_ack = 1'b0;
        for (int r = int'(row_sel); r > 0; r--) brd[ROW_W'(r)] = brd[ROW_W'(r - 1)];
        brd[0] = 1'b0;
      end else if (clear_req) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          check("clear_row", 32'(row_sel), 32'(exp_row));
          clear_ack = 1'b1;
          wait_cnt  = 0;
          ncl++;
        end
      end else if (state == 3'd1) begin
        break;
      end
    end
    check("clear_done_gen", 32'(state), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ncl;
    restart       = 1'b1;
    gen_ack       = 1'b0;
    spawn_blocked = 1'b0;
    placed        = 1'b0;
    clear_ack     = 1'b0;
    pause_btn     = 1'b0;
    brd           = '0;
    cyc(1);
    restart = 1'b0;
    check("rst_state", 32'(state), 0);
    check("rst_gen_req", 32'(gen_req), 0);
    check("rst_drop_tick", 32'(drop_tick), 0);
    check("rst_land", 32'(land), 0);
    check("rst_clear_req", 32'(clear_req), 0);
    check("rst_row_sel", 32'(row_sel), 3);
    check("rst_lines", 32'(lines_total), 0);
    check("rst_level", 32'(level), 0);

    cyc(1);
    check("gen_state", 32'(state), 1);
    check("gen_req_high", 32'(gen_req), 1);
    spawn(1'b0);
    check("move_state", 32'(state), 2);
    check("gen_req_low", 32'(gen_req), 0);

    // Level 0: period 10; run 32 cycles so the lock below lands on tick 40.
    gravity_window(32, 10, "grav_l0");
    placed = 1'b1;
    cyc(3);
    check("lock_run1_move", 32'(state), 2);
    placed = 1'b0;
    cyc(1);
    check("lock_gap_move", 32'(state), 2);
    brd    = 4'b1100;
    placed = 1'b1;
    cyc(3);
    check("lock_run2_move", 32'(state), 2);
    cyc(1);
    placed = 1'b0;
    check("lock_land_state", 32'(state), 3);
    check("land_pulse", 32'(land), 1);
    check("tick_at_lock", 32'(drop_tick), 1);
    cyc(1);
    check("clear_state", 32'(state), 4);
    check("land_low", 32'(land), 0);
    check("tick_low", 32'(drop_tick), 0);
    check("clear_row_start", 32'(row_sel), 3);

    run_clear(60, 3, ncl);
    check("clears_2", 32'(ncl), 2);
    check("lines_2", 32'(lines_total), 2);
    check("level_1", 32'(level), 1);
    check("scan_end_row", 32'(row_sel), 0);
    check("regen_req", 32'(gen_req), 1);

    // Level 1: period 10-4=6.
    spawn(1'b0);
    check("move_l1", 32'(state), 2);
    gravity_window(12, 6, "grav_l1");

    brd = 4'b1111;
    lock_piece();
    cyc(1);
    run_clear(80, 3, ncl);
    check("clears_4", 32'(ncl), 4);
    check("lines_6", 32'(lines_total), 6);
    check("level_3", 32'(level), 3);

    // Level 3: 10-12 clips to the floor of 3.
    spawn(1'b0);
    gravity_window(9, 3, "grav_l3");

    // Restart while a clear request is outstanding, with a coincident ack.
    brd = 4'b1000;
    lock_piece();
    cyc(1);
    check("pend_clear_state", 32'(state), 4);
    cyc(1);
    check("pend_clear_req", 32'(clear_req), 1);
    restart   = 1'b1;
    clear_ack = 1'b1;
    cyc(1);
    restart   = 1'b0;
    clear_ack = 1'b0;
    brd       = '0;
    check("rst2_state", 32'(state), 0);
    check("rst2_clear_req", 32'(clear_req), 0);
    check("rst2_lines", 32'(lines_total), 0);
    check("rst2_level", 32'(level), 0);
    check("rst2_row_sel", 32'(row_sel), 3);

    cyc(1);
    check("gen2_state", 32'(state), 1);
    spawn(1'b1);
    check("gameover_state", 32'(state), 5);
    check("gameover_gen_req", 32'(gen_req), 0);
    gen_ack = 1'b1;
    cyc(1);
    gen_ack = 1'b0;
    cyc(19);
    check("gameover_hold", 32'(state), 5);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    check("rst3_state", 32'(state), 0);
    cyc(1);
    check("rst3_gen", 32'(state), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
- Parametrised next-generation top-level Tetris game controller. It sequences piece generation, gravity, lock delay, row clearing and game over.
- It runs the gravity timer and a level/speed scaler.
- It drives the piece generator, the movement logic and the board RAM through request/acknowledge handshakes.
- It sits between the game top level and the board, piece and movement datapaths.

Parameters:
- ROWS, 20, board height; row index width ROW_W = $clog2(ROWS).
- LOCK_CYCLES, 8, consecutive cycles of placed before a piece locks (1..255).
- DROP_BASE, 1000, gravity period in clka cycles at level 0.
- DROP_STEP, 50, period reduction per level.
- DROP_MIN, 100, gravity period floor.
- LINES_PER_LEVEL, 10, cleared lines per level increment.
- MAX_LEVEL, 15, level saturation value.
- LINES_W, 16, width of the total-lines counter.

Ports:
- clka  in  1  system clock; all state updates on rising edge.
- restart  in  1  synchronous active-high reset / new game.
- gen_ack  in  1  piece generator finished spawning (1-cycle pulse).
- spawn_blocked  in  1  spawn position collides; valid only with gen_ack.
- placed  in  1  active piece cannot move down (level signal from movement logic).
- row_full  in  1  board row addressed by row_sel is full (combinational, same cycle).
- clear_ack  in  1  board finished deleting row_sel and shifting rows above (1-cycle pulse).
- state  out  3  current state encoding.
- gen_req  out  1  request new piece; held until gen_ack.
- drop_tick  out  1  1-cycle gravity pulse to movement logic.
- land  out  1  1-cycle pulse: commit active piece into board.
- row_sel  out  ROW_W  row under test/clear.
- clear_req  out  1  delete row_sel; held until clear_ack.
- lines_total  out  LINES_W  lines cleared this game, saturating.
- level  out  4  current level, saturating at MAX_LEVEL.

Behaviour:
- Reset: restart=1 at any edge forces the following, regardless of state or pending handshake. Pending gen_ack/clear_ack in that cycle are ignored.
  - state=NEWBOARD; all outputs 0; row_sel=ROWS-1.
  - lock counter, gravity counter, lines_total, level and lines-in-level counter cleared.
- Encoding: NEWBOARD=0, GEN=1, MOVE=2, LAND=3, CLEAR=4, GAMEOVER=5, PAUSE=6 (PAUSE only with the optional feature).
- NEWBOARD: one cycle, then GEN.
- GEN: gen_req=1.
  - On gen_ack with spawn_blocked=1 -> GAMEOVER.
  - On gen_ack with spawn_blocked=0 -> MOVE; gravity counter and lock counter cleared.
- MOVE, gravity:
  - Counter increments every cycle. On reaching period-1, drop_tick=1 for one cycle and the counter wraps to 0.
  - period = max(DROP_MIN, DROP_BASE - level*DROP_STEP), computed unsigned without underflow.
- MOVE, lock:
  - Lock counter increments each cycle placed=1 and clears whenever placed=0.
  - When it reaches LOCK_CYCLES-1 while placed=1 -> LAND. A piece locks after exactly LOCK_CYCLES consecutive placed cycles.
  - drop_tick in the same cycle as the lock transition is still emitted.
- LAND: land=1 for one cycle, then CLEAR with row_sel=ROWS-1.
- CLEAR, scan:
  - row_full=0 and row_sel>0: row_sel decrements.
  - row_full=0 and row_sel=0: -> GEN.
  - row_full=1: clear_req=1 and row_sel is held until clear_ack.
- CLEAR, on clear_ack:
  - clear_req drops; lines_total increments (saturating at all-ones); lines-in-level increments.
  - The same row_sel is rescanned, because rows shifted down.
  - When lines-in-level reaches LINES_PER_LEVEL, it resets to 0 and level increments (saturating at MAX_LEVEL).
  - A new level's period takes effect at the next MOVE entry.
- GAMEOVER: hold. Only restart exits.
- gen_ack or clear_ack arriving outside its wait state is ignored.

Optional Feature:
- Macro GAME_CTRL_PAUSE_EN adds input port pause_btn (1 bit, level).
- With it defined:
  - In MOVE, a rising edge of pause_btn -> PAUSE. Gravity and lock counters freeze and drop_tick=0.
  - The next rising edge of pause_btn -> MOVE with counters resumed unchanged.
  - restart overrides PAUSE.
- Without it: no port, no PAUSE state; encoding 6 is unreachable and the default branch maps it to NEWBOARD.

Decomposition:
- Package game_ctrl_pkg holds:
  - state encoding constants;
  - the default parameter values;
  - the ROW_W derivation function.
- Sub-module gravity_timer contains:
  - the period computation from level;
  - the counter with clear/freeze inputs;
  - the drop_tick generation.

Test Plan:
- Reset and spawn: restart 1 cycle, then gen_ack with spawn_blocked=0 at cycle 3 -> NEWBOARD, GEN (gen_req=1), MOVE at cycle 4; all counters 0.
- Gravity: DROP_BASE=10, level 0, placed=0 -> drop_tick every 10 cycles, exactly 1 cycle wide.
- Lock: LOCK_CYCLES=4, placed high 3 cycles, low 1, high 4 -> LAND entered only after the second run; land pulse 1 cycle.
- Clear: ROWS=4, rows 3 and 2 full, clear_ack 2 cycles after each clear_req -> two clears at row_sel=3, lines_total=2, scan continues to 0, then GEN.
- Level: LINES_PER_LEVEL=2, DROP_BASE=10, DROP_STEP=4, DROP_MIN=3, clear 6 lines -> level=3, period=max(3,-2 clipped)=3.
- Game over and restart mid-CLEAR: spawn_blocked=1 with gen_ack -> GAMEOVER held 20 cycles; restart during a pending clear_req -> NEWBOARD, clear_req=0, lines_total=0.
